// File: rtl/rgmii_tx_decoder.sv
// Decodes RGMII TX samples (already captured to clk) into a GMII byte stream with a one-cycle enable strobe.
// 1000M decodes every cycle; 10/100 assembles nibble pairs on forwarded-clock edges and counts frames and errors.
module rgmii_tx_decoder #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           rgmii_d1,
  input  logic [3:0]           rgmii_d2,
  input  logic                 rgmii_ctl1,
  input  logic                 rgmii_ctl2,
  input  logic                 rgmii_clk_s,
  input  logic [1:0]           speed,
  output logic [7:0]           gmii_rxd,
  output logic                 gmii_rx_dv,
  output logic                 gmii_rx_er,
  output logic                 gmii_clk_en,
  output logic                 align_err,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t     state, state_nxt;
  logic       clk_prev;
  logic       en_bit;
  logic       er_acc;
  logic [3:0] nib;
  logic [3:0] low_nib;
  logic [1:0] speed_prev;
  logic       spd_vld;

  logic       gig, spd_chg, rise, fall, er_bit, commit;
  logic       store_low, emit, emit_dv, emit_er, emit_align;
  logic [7:0] emit_rxd;
  logic       frame_inc;
  logic [1:0] err_inc;

  assign gig     = speed[1];
  // spd_vld keeps the first cycle after reset from looking like a speed change
  assign spd_chg = spd_vld && (speed != speed_prev);
  assign rise    = rgmii_clk_s & ~clk_prev;
  assign fall    = ~rgmii_clk_s & clk_prev;
  assign er_bit  = rgmii_ctl1 ^ en_bit;
  assign commit  = !gig && !spd_chg && fall;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [1:0] inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, c} + (CNT_WIDTH+1)'(inc);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    store_low  = 1'b0;
    emit       = 1'b0;
    emit_dv    = 1'b0;
    emit_er    = 1'b0;
    emit_align = 1'b0;
    emit_rxd   = 8'h00;
    frame_inc  = 1'b0;
    err_inc    = 2'd0;
    if (spd_chg) begin
      state_nxt = IDLE;
    end else if (gig) begin
      frame_inc = gmii_rx_dv & ~rgmii_ctl1;
      err_inc   = {1'b0, rgmii_ctl1 ^ rgmii_ctl2};
    end else if (commit) begin
      case (state)
        IDLE: if (en_bit) begin
          store_low = 1'b1;
          state_nxt = HIGH;
        end
        HIGH: if (en_bit) begin
          emit      = 1'b1;
          emit_dv   = 1'b1;
          emit_er   = er_acc | er_bit;
          emit_rxd  = {nib, low_nib};
          state_nxt = LOW;
        end else begin
          emit       = 1'b1;
          emit_align = 1'b1;
          state_nxt  = IDLE;
        end
        LOW: if (en_bit) begin
          store_low = 1'b1;
          state_nxt = HIGH;
        end else begin
          emit      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
      frame_inc = emit & ~emit_dv;
      err_inc   = {1'b0, emit_dv & emit_er} + {1'b0, emit_align};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_prev    <= 1'b0;
      en_bit      <= 1'b0;
      er_acc      <= 1'b0;
      nib         <= 4'h0;
      low_nib     <= 4'h0;
      speed_prev  <= 2'b00;
      spd_vld     <= 1'b0;
      gmii_rxd    <= 8'h00;
      gmii_rx_dv  <= 1'b0;
      gmii_rx_er  <= 1'b0;
      gmii_clk_en <= 1'b0;
      align_err   <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      clk_prev    <= rgmii_clk_s;
      speed_prev  <= speed;
      spd_vld     <= 1'b1;
      align_err   <= emit_align;
      frame_count <= sat_add(frame_count, {1'b0, frame_inc});
      err_count   <= sat_add(err_count, err_inc);
      if (spd_chg) begin
        gmii_clk_en <= 1'b0;
        gmii_rxd    <= 8'h00;
        gmii_rx_dv  <= 1'b0;
        gmii_rx_er  <= 1'b0;
        en_bit      <= 1'b0;
        er_acc      <= 1'b0;
        nib         <= 4'h0;
        low_nib     <= 4'h0;
      end else if (gig) begin
        gmii_rxd    <= {rgmii_d2, rgmii_d1};
        gmii_rx_dv  <= rgmii_ctl1;
        gmii_rx_er  <= rgmii_ctl1 ^ rgmii_ctl2;
        gmii_clk_en <= 1'b1;
      end else begin
        gmii_clk_en <= emit;
        if (emit) begin
          gmii_rxd   <= emit_rxd;
          gmii_rx_dv <= emit_dv;
          gmii_rx_er <= emit_er;
        end
        if (rise) begin
          nib    <= rgmii_d1;
          en_bit <= rgmii_ctl1;
        end
        if (store_low) begin
          low_nib <= nib;
          er_acc  <= er_bit;
        end
      end
    end
  end

endmodule

// File: doc/rgmii_tx_decoder.md
RGMII_TX_DECODER -- requirements
Module: rgmii_tx_decoder

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of the frame and error counters.
REQ-002 SHALL have port clk, input, 1: single clock for all logic, 125 MHz.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 SHALL have port rgmii_d1, input, 4: rising-edge data nibble, already captured to clk.
REQ-005 SHALL have port rgmii_d2, input, 4: falling-edge data nibble, already captured to clk.
REQ-006 SHALL have port rgmii_ctl1 / rgmii_ctl2, input, 1 each: rising-edge and falling-edge CTL samples.
REQ-007 SHALL have port rgmii_clk_s, input, 1: forwarded TX clock level sampled once per clk cycle; used at 10/100 only.
REQ-008 SHALL have port speed, input, 2: 00 = 10M, 01 = 100M, 1x = 1000M.
REQ-009 SHALL have port gmii_rxd, output, 8: decoded byte.
REQ-010 SHALL have ports gmii_rx_dv and gmii_rx_er, output, 1 each: byte qualifiers.
REQ-011 SHALL have port gmii_clk_en, output, 1: one-cycle strobe; gmii_rxd, gmii_rx_dv and gmii_rx_er are valid only when it is 1.
REQ-012 SHALL have port align_err, output, 1: one-cycle pulse when a frame ends on an odd nibble.
REQ-013 SHALL have ports frame_count and err_count, output, CNT_WIDTH each: event counters.

Function
REQ-014 SHALL, at 1000M, register each cycle: gmii_rxd = {rgmii_d2, rgmii_d1}; dv = ctl1; er = ctl1 ^ ctl2; gmii_clk_en = 1. Latency is 1 clk.
REQ-015 SHALL, at 10/100, keep a register clk_prev (the previous rgmii_clk_s) with rise = rgmii_clk_s & ~clk_prev and fall = ~rgmii_clk_s & clk_prev.
REQ-016 SHALL, on a rise, capture nib = rgmii_d1 and en_bit = rgmii_ctl1.
REQ-017 SHALL, on a fall, form er_bit = rgmii_ctl1 ^ en_bit and commit the nibble to the FSM.
REQ-018 SHALL implement an FSM with states IDLE, LOW and HIGH, evaluated only on nibble commit at 10/100.
REQ-019 SHALL, in IDLE: en_bit = 1 -> store the low nibble, er_acc = er_bit, go to HIGH; en_bit = 0 -> stay in IDLE with no strobe.
REQ-020 SHALL, in HIGH: en_bit = 1 -> emit byte {nib, low}, dv = 1, er = er_acc | er_bit, go to LOW.
REQ-021 SHALL, in HIGH with en_bit = 0 -> emit an end strobe (dv = 0, er = 0, rxd = 0), pulse align_err, increment err_count, go to IDLE; the partial nibble is discarded.
REQ-022 SHALL, in LOW: en_bit = 1 -> store the low nibble, er_acc = er_bit, go to HIGH; en_bit = 0 -> emit an end strobe and go to IDLE.
REQ-023 SHALL assert the 10/100 emit strobe gmii_clk_en exactly 1 clk after the committing fall, held for 1 cycle.
REQ-024 SHALL increment frame_count once per frame end: dv falling at 1000M, or any end strobe at 10/100 (including the odd-nibble case).
REQ-025 SHALL increment err_count on each emitted byte with er = 1, and on each align_err pulse.
REQ-026 SHALL increment err_count by 2 when both events occur in the same cycle.
REQ-027 SHALL saturate both counters at all-ones.
REQ-028 SHALL, when speed changes, force the FSM to IDLE and discard any partial nibble, with no strobe and no count, during the cycle in which the change is seen.
REQ-029 SHALL ignore a rise and a fall in the same cycle, which cannot occur since they are mutually exclusive by construction.
REQ-030 SHALL hold gmii_clk_en at 0 at 10/100 except for emit strobes.

Reset
REQ-031 SHALL, while rst = 0 at a clk edge, clear all outputs, counters, clk_prev, er_acc and stored nibbles to 0, and set the FSM to IDLE.
REQ-032 SHALL abandon any in-progress frame on reset mid-frame, with no end strobe and no count.
REQ-033 SHALL begin decoding on the first clk edge with rst = 1.

Verification
REQ-034 SHALL cover: 1000M, ctl1 = ctl2 = 1, d1 = 5, d2 = A for 8 cycles, then ctl = 0 -> 8 strobes with rxd = 0xA5, dv = 1, er = 0, then frame_count = 1.
REQ-035 SHALL cover: 1000M byte with ctl1 = 1, ctl2 = 0 -> er = 1, err_count = 1.
REQ-036 SHALL cover: 100M (clk_s period 5 cycles), nibbles 5 then A with en = 1, then en = 0 -> one strobe rxd = 0xA5, dv = 1, then an end strobe with dv = 0, frame_count = 1.
REQ-037 SHALL cover: 10M (period 50), 3 nibbles then en = 0 -> one data byte, then align_err pulse, frame_count = 1, err_count = 1.
REQ-038 SHALL cover: speed changes 01->10 after one low nibble -> no strobe from the partial nibble, and 1000M decoding is correct on the next cycle.
REQ-039 SHALL cover: rst = 0 mid-frame at 100M -> all outputs 0 the next cycle; the subsequent frame decodes correctly with counters restarted from 0.
